// File: rtl/offchip_rx_unpack_if.sv
// rtl/offchip_rx_unpack_if.sv - link-side and word-side signal bundle for offchip_rx_unpack
// The link_par signal exists only when OFFCHIP_RX_PARITY_EN is defined.
interface offchip_rx_unpack_if;
    logic [15:0] link_data;
    logic        link_valid;
`ifdef OFFCHIP_RX_PARITY_EN
    logic        link_par;
`endif
    logic        credit_ret;
    logic [63:0] data_out;
    logic        valid_out;
    logic        ready;

`ifdef OFFCHIP_RX_PARITY_EN
    modport master (output link_data, link_valid, link_par, ready,
                    input  credit_ret, data_out, valid_out);
    modport slave  (input  link_data, link_valid, link_par, ready,
                    output credit_ret, data_out, valid_out);
`else
    modport master (output link_data, link_valid, ready,
                    input  credit_ret, data_out, valid_out);
    modport slave  (input  link_data, link_valid, ready,
                    output credit_ret, data_out, valid_out);
`endif
endinterface

// File: rtl/offchip_rx_unpack.sv
// rtl/offchip_rx_unpack.sv - off-chip flit receiver: credit-managed flit FIFO plus 4-flit to 64-bit reassembly
// Optional link parity checking is enabled by defining OFFCHIP_RX_PARITY_EN.
module offchip_rx_unpack #(
    parameter int DEPTH       = 8,
    parameter int CREDIT_GRAN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    offchip_rx_unpack_if.slave    rx,
`ifdef OFFCHIP_RX_PARITY_EN
    output logic                  par_err,
`endif
    output logic                  overflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(CREDIT_GRAN);

    typedef enum logic [2:0] {S_COL0, S_COL1, S_COL2, S_COL3, S_HOLD} state_t;

    state_t         state_q, state_d;
    logic [15:0]    mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  pop_cnt_q;
    logic           credit_q;
    logic [47:0]    lane_q;
    logic [63:0]    data_out_q;
    logic           overflow_q;
    logic           full, empty, push, pop;
    logic [15:0]    flit;

    // Pointers carry one extra wrap bit, so full means "same slot, opposite lap".
    assign full  = ((wr_ptr_q ^ rd_ptr_q) == PW'(DEPTH));
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = rx.link_valid && !full;
    assign flit  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_COL0;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_COL0: if (!empty) begin pop = 1'b1; state_d = S_COL1; end
            S_COL1: if (!empty) begin pop = 1'b1; state_d = S_COL2; end
            S_COL2: if (!empty) begin pop = 1'b1; state_d = S_COL3; end
            S_COL3: if (!empty) begin pop = 1'b1; state_d = S_HOLD; end
            S_HOLD: if (rx.ready) state_d = S_COL0;
            default: state_d = S_COL0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= rx.link_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pop_cnt_q  <= '0;
            credit_q   <= 1'b0;
            lane_q     <= '0;
            data_out_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                pop_cnt_q <= pop_cnt_q + 1'b1;
            end
            credit_q <= pop && (pop_cnt_q == CW'(CREDIT_GRAN - 1));
            if (rx.link_valid && full) overflow_q <= 1'b1;
            if (pop) begin
                case (state_q)
                    S_COL0: lane_q[15:0]  <= flit;
                    S_COL1: lane_q[31:16] <= flit;
                    S_COL2: lane_q[47:32] <= flit;
                    // Lane 3 bypasses lane_q so the word is complete on this same edge.
                    S_COL3: data_out_q <= {flit[15:8], lane_q[47:40], lane_q[31:24], lane_q[15:8],
                                           flit[7:0],  lane_q[39:32], lane_q[23:16], lane_q[7:0]};
                    default: ;
                endcase
            end
        end
    end

`ifdef OFFCHIP_RX_PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk) begin
        if (rst)                                          par_err_q <= 1'b0;
        else if (push && !(^{rx.link_data, rx.link_par})) par_err_q <= 1'b1;
    end

    assign par_err = par_err_q;
`endif

    assign rx.valid_out  = (state_q == S_HOLD);
    assign rx.data_out   = data_out_q;
    assign rx.credit_ret = credit_q;
    assign overflow_err  = overflow_q;
endmodule

// File: tb/tb_offchip_rx_unpack.sv
// tb/tb_offchip_rx_unpack.sv - self-checking bench for offchip_rx_unpack (directed scenarios plus randomized run)
module tb_offchip_rx_unpack;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    logic overflow_err;
`ifdef OFFCHIP_RX_PARITY_EN
    logic par_err;
`endif
    int checks = 0;
    int errors = 0;

    offchip_rx_unpack_if bus ();

    offchip_rx_unpack #(.DEPTH(DEPTH), .CREDIT_GRAN(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (bus),
`ifdef OFFCHIP_RX_PARITY_EN
        .par_err      (par_err),
`endif
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_flit(input logic [15:0] f);
        bus.link_valid = 1'b1;
        bus.link_data  = f;
`ifdef OFFCHIP_RX_PARITY_EN
        bus.link_par   = ~^f;
`endif
    endtask

    task automatic drive_idle;
        bus.link_valid = 1'b0;
        bus.link_data  = 16'h0;
`ifdef OFFCHIP_RX_PARITY_EN
        bus.link_par   = 1'b0;
`endif
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive_idle();
        bus.ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Flit k of a word lands in byte k (low byte) and byte k+4 (high byte).
    function automatic logic [63:0] build_word(input logic [63:0] flits);
        logic [63:0] w = 64'h0;
        for (int k = 0; k < 4; k++) begin
            logic [15:0] f = flits[16*k +: 16];
            w = w | (64'(f[7:0]) << (8 * k)) | (64'(f[15:8]) << (8 * k + 32));
        end
        return w;
    endfunction

    task automatic test_reset;
        do_reset();
        checks++;
        if (bus.valid_out !== 1'b0 || bus.credit_ret !== 1'b0 || bus.data_out !== 64'h0 || overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b credit=%b data=%h ovf=%b, required all 0",
                     bus.valid_out, bus.credit_ret, bus.data_out, overflow_err);
        end
`ifdef OFFCHIP_RX_PARITY_EN
        checks++;
        if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b required 0", par_err); end
`endif
    endtask

    task automatic test_basic;
        logic [15:0] fl [4] = '{16'h4488, 16'h3377, 16'h2266, 16'h1155};
        do_reset();
        bus.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_flit(fl[i]);
            tick();
            checks++;
            if (bus.valid_out !== 1'b0 || bus.credit_ret !== 1'b0) begin
                errors++;
                $display("FAIL basic_early_valid: edge %0d valid=%b credit=%b, required 0 0", i, bus.valid_out, bus.credit_ret);
            end
        end
        drive_idle();
        tick();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.credit_ret !== 1'b1 || bus.data_out !== 64'h1122334455667788) begin
            errors++;
            $display("FAIL basic_word: valid=%b credit=%b data=%h, required 1 1 1122334455667788",
                     bus.valid_out, bus.credit_ret, bus.data_out);
        end
        tick();
        checks++;
        if (bus.valid_out !== 1'b0 || bus.credit_ret !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept: valid=%b credit=%b, required 0 0", bus.valid_out, bus.credit_ret);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] fa, fb;
        int cr = 0;
        int n;
        fa = {$urandom, $urandom};
        fb = {$urandom, $urandom};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_flit(i < 4 ? fa[16*i +: 16] : fb[16*(i-4) +: 16]);
            tick();
            if (bus.credit_ret) cr++;
        end
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.credit_ret) cr++;
            checks++;
            if (bus.valid_out !== 1'b1 || bus.data_out !== build_word(fa)) begin
                errors++;
                $display("FAIL bp_hold_A: valid=%b data=%h, required 1 %h", bus.valid_out, bus.data_out, build_word(fa));
            end
        end
        checks++;
        if (cr != 1) begin errors++; $display("FAIL bp_one_credit: got %0d pulses required 1", cr); end
        bus.ready = 1'b1;
        tick();
        n = 1;
        checks++;
        if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL bp_accept_A: valid=%b required 0", bus.valid_out); end
        while (!bus.valid_out && n < 12) begin
            tick();
            n++;
        end
        checks++;
        if (n != 5 || bus.valid_out !== 1'b1 || bus.credit_ret !== 1'b1 || bus.data_out !== build_word(fb)) begin
            errors++;
            $display("FAIL bp_word_B: cycles=%0d valid=%b credit=%b data=%h, required 5 1 1 %h",
                     n, bus.valid_out, bus.credit_ret, bus.data_out, build_word(fb));
        end
        tick();
        checks++;
        if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL bp_accept_B: valid=%b required 0", bus.valid_out); end
    endtask

    // Four flits sit in the assembler/HOLD word, so the buffer fills only at flit 12; flit 13 is dropped.
    task automatic test_overflow;
        logic [15:0] fl [13];
        logic [63:0] w;
        int idx = 0;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            fl[i] = 16'($urandom);
            drive_flit(fl[i]);
            tick();
            if (i == 11) begin
                checks++;
                if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b required 0", overflow_err); end
            end
        end
        drive_idle();
        checks++;
        if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", overflow_err); end
        bus.ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.valid_out) begin
                w = (idx < 3) ? build_word({fl[4*idx+3], fl[4*idx+2], fl[4*idx+1], fl[4*idx]}) : 64'h0;
                checks++;
                if (idx >= 3 || bus.data_out !== w) begin
                    errors++;
                    $display("FAIL ovf_word%0d: got %h required %h", idx, bus.data_out, w);
                end
                idx++;
            end
            tick();
        end
        checks++;
        if (idx != 3 || overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_word_count: words=%0d ovf=%b, required 3 1", idx, overflow_err);
        end
    endtask

    task automatic test_gapped;
        logic [63:0] f;
        f = {$urandom, $urandom};
        do_reset();
        bus.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_flit(f[16*i +: 16]);
            tick();
            drive_idle();
            checks++;
            if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL gap_push%0d: valid=%b required 0", i, bus.valid_out); end
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    checks++;
                    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL gap_idle%0d: valid=%b required 0", i, bus.valid_out); end
                end
            end
        end
        tick();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.credit_ret !== 1'b1 || bus.data_out !== build_word(f)) begin
            errors++;
            $display("FAIL gap_word: valid=%b credit=%b data=%h, required 1 1 %h",
                     bus.valid_out, bus.credit_ret, bus.data_out, build_word(f));
        end
        tick();
    endtask

    // Runs straight after test_overflow, so the reset here must also clear the sticky overflow flag.
    task automatic test_mid_reset;
        bus.ready = 1'b1;
        drive_flit(16'hA5C3);
        tick();
        drive_flit(16'h5A3C);
        tick();
        do_reset();
        bus.ready = 1'b1;
        checks++;
        if (overflow_err !== 1'b0 || bus.credit_ret !== 1'b0 || bus.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear: ovf=%b credit=%b valid=%b, required 0 0 0", overflow_err, bus.credit_ret, bus.valid_out);
        end
        for (int i = 0; i < 4; i++) begin
            drive_flit(16'h0000);
            tick();
        end
        drive_idle();
        tick();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset_word: valid=%b data=%h, required 1 0000000000000000", bus.valid_out, bus.data_out);
        end
        tick();
    endtask

`ifdef OFFCHIP_RX_PARITY_EN
    task automatic test_parity;
        logic [15:0] fl [4] = '{16'h4488, 16'h3377, 16'h2266, 16'h1155};
        do_reset();
        bus.ready      = 1'b1;
        bus.link_valid = 1'b1;
        bus.link_data  = 16'h4488;
        bus.link_par   = 1'b0;
        tick();
        checks++;
        if (par_err !== 1'b1) begin errors++; $display("FAIL par_set: got %b required 1", par_err); end
        for (int i = 1; i < 4; i++) begin
            drive_flit(fl[i]);
            tick();
        end
        drive_idle();
        tick();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== 64'h1122334455667788 || par_err !== 1'b1) begin
            errors++;
            $display("FAIL par_word: valid=%b data=%h par_err=%b, required 1 1122334455667788 1",
                     bus.valid_out, bus.data_out, par_err);
        end
        tick();
    endtask
`endif

    // Injection is throttled so pushed-minus-consumed never reaches DEPTH, hence no drops are expected.
    task automatic test_random;
        logic [15:0] model_q [$];
        logic [63:0] pre_data, exp_w;
        logic        pre_valid, prev_credit, drain;
        int          pushed = 0, accepted = 0, credits = 0, presented = 0;
        do_reset();
        prev_credit = 1'b0;
        for (int c = 0; c < 3040; c++) begin
            drain     = (c >= 3000);
            bus.ready = drain ? 1'b1 : ($urandom_range(0, 9) < 6);
            if (!drain && $urandom_range(0, 9) < 6 && (pushed - 4 * accepted) < DEPTH) begin
                drive_flit(16'($urandom));
                model_q.push_back(bus.link_data);
                pushed++;
            end else begin
                drive_idle();
            end
            pre_valid = bus.valid_out;
            pre_data  = bus.data_out;
            tick();
            if (pre_valid && bus.ready) begin
                checks++;
                if (model_q.size() < 4) begin
                    errors++;
                    $display("FAIL rnd_extra_word: got %h with only %0d flits outstanding", pre_data, model_q.size());
                end else begin
                    exp_w = build_word({model_q[3], model_q[2], model_q[1], model_q[0]});
                    repeat (4) void'(model_q.pop_front());
                    if (pre_data !== exp_w) begin
                        errors++;
                        $display("FAIL rnd_word%0d: got %h required %h", accepted, pre_data, exp_w);
                    end
                end
                accepted++;
            end else if (pre_valid) begin
                checks++;
                if (bus.valid_out !== 1'b1 || bus.data_out !== pre_data) begin
                    errors++;
                    $display("FAIL rnd_hold: valid=%b data=%h, required 1 %h", bus.valid_out, bus.data_out, pre_data);
                end
            end
            if (bus.valid_out && !pre_valid) begin
                presented++;
                checks++;
                if (bus.credit_ret !== 1'b1) begin errors++; $display("FAIL rnd_credit_with_valid: credit=%b required 1", bus.credit_ret); end
            end
            if (bus.credit_ret) begin
                credits++;
                checks++;
                if (prev_credit || pre_valid || !bus.valid_out) begin
                    errors++;
                    $display("FAIL rnd_credit_pulse: prev_credit=%b pre_valid=%b valid=%b, required 0 0 1",
                             prev_credit, pre_valid, bus.valid_out);
                end
            end
            prev_credit = bus.credit_ret;
        end
        checks++;
        if (accepted != pushed / 4 || credits != pushed / 4 || presented != pushed / 4 || overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL rnd_totals: accepted=%0d credits=%0d presented=%0d ovf=%b, required %0d each and ovf 0",
                     accepted, credits, presented, overflow_err, pushed / 4);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.ready = 1'b0;
        drive_idle();
        test_reset();
        test_basic();
        test_back_to_back();
        test_gapped();
        test_overflow();
        test_mid_reset();
`ifdef OFFCHIP_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
